ucode_loader: RTL

Streaming writer for the microprogram control store read by the control unit. It accepts a framed byte stream over a valid/ready handshake, assembles store words, writes them into consecutive control-store addresses, and checks a trailing XOR checksum. While a load is in progress it holds the CPU off through `hold_cpu`, which the top level ORs into the control unit's `rst`, so the microsequencer restarts at address 0 after every load.

---
 rtl/ucode_loader_if.sv | 26 ++
 rtl/ucode_loader.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ucode_loader_if.sv
// Byte-stream input and control-store write port of the microcode loader.
// Status lines (hold_cpu, done, err) travel with the bundle.
interface ucode_loader_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 6
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              hold_cpu;
  logic              done;
  logic              err;

  modport master (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, hold_cpu, done, err
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, hold_cpu, done, err
  );
endinterface

// File: rtl/ucode_loader.sv
// Framed byte-stream loader for the microprogram control store.
// Frame: A5, count, start address, count words (MSB byte first), XOR checksum.
module ucode_loader #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  ucode_loader_if.master bus
);
  localparam int         NB     = WORD_W / 8;
  localparam int         BCNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [7:0] SYNC   = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CNT  = 3'd1,
    S_ADR  = 3'd2,
    S_DAT  = 3'd3,
    S_CHK  = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         xor_q, xor_d;
  logic [WORD_W-1:0]  asm_q, asm_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0]  wr_data_q, wr_data_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               hold_q, hold_d;
  logic               xfer_s;
  logic [WORD_W-1:0]  asm_shift_s;

  // in_ready is not registered: it must be low under reset yet high in the first cycle after release.
  assign bus.in_ready = ~rst & (state_q != S_ERR);
  assign xfer_s       = bus.in_valid & bus.in_ready;
  assign asm_shift_s  = (asm_q << 8) | WORD_W'(bus.in_data);

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.hold_cpu = hold_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      bcnt_q    <= '0;
      addr_q    <= '0;
      xor_q     <= 8'd0;
      asm_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bcnt_q    <= bcnt_d;
      addr_q    <= addr_d;
      xor_q     <= xor_d;
      asm_q     <= asm_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      hold_q    <= hold_d;
    end
  end

  // Next-state and output decode; strobes default low, everything else holds.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bcnt_d    = bcnt_q;
    addr_d    = addr_q;
    xor_d     = xor_q;
    asm_d     = asm_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = err_q;
    hold_d    = hold_q;

    case (state_q)
      S_IDLE: begin
        if (xfer_s && (bus.in_data == SYNC)) begin
          state_d = S_CNT;
          err_d   = 1'b0;
          hold_d  = 1'b1;
          xor_d   = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CNT: begin
        if (xfer_s && (bus.in_data == 8'd0)) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          hold_d  = 1'b0;
        end else if (xfer_s) begin
          state_d = S_ADR;
          cnt_d   = bus.in_data;
          xor_d   = bus.in_data;
        end else begin
          state_d = S_CNT;
        end
      end
      S_ADR: begin
        if (xfer_s) begin
          state_d = S_DAT;
          addr_d  = ADDR_W'(bus.in_data);
          xor_d   = xor_q ^ bus.in_data;
          bcnt_d  = '0;
        end else begin
          state_d = S_ADR;
        end
      end
      S_DAT: begin
        if (xfer_s) begin
          xor_d = xor_q ^ bus.in_data;
          asm_d = asm_shift_s;
          if (bcnt_q == BCNT_W'(NB - 1)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = asm_shift_s;
            addr_d    = addr_q + 1'b1;
            bcnt_d    = '0;
            cnt_d     = cnt_q - 8'd1;
            state_d   = (cnt_q == 8'd1) ? S_CHK : S_DAT;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end else begin
          state_d = S_DAT;
        end
      end
      S_CHK: begin
        if (xfer_s && (bus.in_data == xor_q)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          hold_d  = 1'b0;
        end else if (xfer_s) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          hold_d  = 1'b0;
        end else begin
          state_d = S_CHK;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end
endmodule
